// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the master and slave adapters: transfer
// encodings, size constants, strobe patterns and the size/alignment check.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;
  localparam logic [2:0] HSIZE_128   = 3'd4;
  localparam logic [2:0] HSIZE_256   = 3'd5;
  localparam logic [2:0] HSIZE_512   = 3'd6;
  localparam logic [2:0] HSIZE_1024  = 3'd7;

  // Byte-lane strobe pattern at lane 0 for sizes up to a doubleword.
  localparam logic [7:0] STRB_MAP [4] = '{8'h01, 8'h03, 8'h0F, 8'hFF};

  // A transfer is legal when its size fits the bus and the address is
  // naturally aligned to that size.
  function automatic logic size_addr_ok(input logic [2:0] size,
                                        input logic [2:0] max_size,
                                        input logic [6:0] addr_lo);
    logic [6:0] mask;
    mask = 7'((8'd1 << size) - 8'd1);
    return (size <= max_size) && ((addr_lo & mask) == '0);
  endfunction

endpackage

// File: rtl/ahb_lite_master_adapter.sv
// Valid/ready request stream to AHB-Lite SINGLE transfers, with pipelined
// address/data phases and an in-order response strobe.
module ahb_lite_master_adapter
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          SEC_TRANS  = 1'b0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [2:0]            HBURST,
  output logic [2:0]            HSIZE,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic                  HNONSEC,
  output logic [DATA_WIDTH-1:0] HWDATA,
  input  logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err
);

  if (DATA_WIDTH < 8 || DATA_WIDTH > 1024 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_width
    $fatal(1, "ahb_lite_master_adapter: DATA_WIDTH %0d unsupported", DATA_WIDTH);
  end

  localparam int unsigned MAX_SIZE = $clog2(DATA_WIDTH / 8);

  logic                  r_a_vld;
  logic                  r_a_bus;
  logic [ADDR_WIDTH-1:0] r_a_addr;
  logic [2:0]            r_a_size;
  logic                  r_a_write;
  logic [DATA_WIDTH-1:0] r_a_wdata;

  logic                  r_d_vld;
  logic                  r_d_bus;
  logic                  r_d_write;
  logic [DATA_WIDTH-1:0] r_d_wdata;

  logic                  r_rsp_valid;
  logic                  r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;

  logic                  w_accept;
  logic                  w_req_ok;
  logic                  w_a_load;

  assign req_ready = ~r_a_vld | HREADY;
  assign w_accept  = req_valid & req_ready;
  assign w_req_ok  = size_addr_ok(req_size, 3'(MAX_SIZE), 7'(req_addr));
  // An empty A stage may take a request during a wait state; otherwise the
  // ready handshake would accept a request that then has nowhere to go.
  assign w_a_load  = HREADY | ~r_a_vld;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_a_vld   <= 1'b0;
      r_a_bus   <= 1'b0;
      r_a_addr  <= '0;
      r_a_size  <= '0;
      r_a_write <= 1'b0;
      r_a_wdata <= '0;
    end else if (w_a_load) begin
      r_a_vld <= w_accept;
      if (w_accept) begin
        r_a_bus   <= w_req_ok;
        r_a_addr  <= req_addr;
        r_a_size  <= req_size;
        r_a_write <= req_write;
        r_a_wdata <= req_wdata;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_d_vld   <= 1'b0;
      r_d_bus   <= 1'b0;
      r_d_write <= 1'b0;
      r_d_wdata <= '0;
    end else if (HREADY) begin
      r_d_vld   <= r_a_vld;
      r_d_bus   <= r_a_bus;
      r_d_write <= r_a_write;
      r_d_wdata <= r_a_wdata;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (r_d_vld && HREADY) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= r_d_bus ? HRESP : 1'b1;
      r_rsp_rdata <= (r_d_bus && !r_d_write && !HRESP) ? HRDATA : '0;
    end else begin
      r_rsp_valid <= 1'b0;
    end
  end

  assign HADDR     = r_a_addr;
  assign HSIZE     = r_a_size;
  assign HWRITE    = r_a_write;
  assign HTRANS    = (r_a_vld && r_a_bus) ? NONSEQ : IDLE;
  assign HBURST    = HBURST_SINGLE;
  assign HNONSEC   = ~SEC_TRANS;
  assign HWDATA    = r_d_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
